// File: rtl/comparator_search.sv
// Successive-approximation searcher driving an external comparator to recover
// its hidden operand B, followed by a single equality confirmation probe.
module comparator_search #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] cmp_a,
    output logic [1:0]       cmp_sel,
    input  logic             cmp_o,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             match
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [WIDTH-1:0] ONE_HOT0 = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_HOT  = WIDTH'(1) << (WIDTH - 1);
    localparam logic [WIDTH-1:0] ZERO_W   = WIDTH'(0);

    localparam logic [1:0] SEL_GT   = 2'b00;
    localparam logic [1:0] SEL_EQ   = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_PROBE  = 2'b01,
        ST_VERIFY = 2'b10
    } state_t;

    state_t             state_q,   state_d;
    logic [WIDTH-1:0]   working_q, working_d;
    logic [IDX_W-1:0]   idx_q,     idx_d;
    logic [WIDTH-1:0]   cmp_a_q,   cmp_a_d;
    logic [1:0]         cmp_sel_q, cmp_sel_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic [WIDTH-1:0]   result_q,  result_d;
    logic               match_q,   match_d;
    logic [WIDTH-1:0]   probe_upd_s;

    // Next-state and next-output computation for the search sequencer.
    always_comb begin
        state_d   = state_q;
        working_d = working_q;
        idx_d     = idx_q;
        cmp_a_d   = cmp_a_q;
        cmp_sel_d = cmp_sel_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;
        match_d   = match_q;

        // A "greater" answer means the trial bit overshoots B and must be dropped.
        probe_upd_s        = cmp_a_q;
        probe_upd_s[idx_q] = ~cmp_o;

        case (state_q)
            ST_IDLE: begin
                cmp_sel_d = SEL_ZERO;
                cmp_a_d   = ZERO_W;
                busy_d    = 1'b0;
                if (start && !abort) begin
                    working_d = ZERO_W;
                    idx_d     = IDX_MAX;
                    cmp_a_d   = MSB_HOT;
                    cmp_sel_d = SEL_GT;
                    busy_d    = 1'b1;
                    state_d   = ST_PROBE;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_PROBE: begin
                if (abort) begin
                    cmp_sel_d = SEL_ZERO;
                    cmp_a_d   = ZERO_W;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    working_d = probe_upd_s;
                    if (idx_q != IDX_ZERO) begin
                        idx_d   = idx_q - IDX_ONE;
                        cmp_a_d = probe_upd_s | (ONE_HOT0 << (idx_q - IDX_ONE));
                    end else begin
                        cmp_a_d   = probe_upd_s;
                        cmp_sel_d = SEL_EQ;
                        state_d   = ST_VERIFY;
                    end
                end
            end
            ST_VERIFY: begin
                cmp_sel_d = SEL_ZERO;
                cmp_a_d   = ZERO_W;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
                if (abort) begin
                    done_d = 1'b0;
                end else begin
                    result_d = working_q;
                    match_d  = cmp_o;
                    done_d   = 1'b1;
                end
            end
            default: begin
                cmp_sel_d = SEL_ZERO;
                cmp_a_d   = ZERO_W;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            working_q <= ZERO_W;
            idx_q     <= IDX_MAX;
            cmp_a_q   <= ZERO_W;
            cmp_sel_q <= SEL_ZERO;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= ZERO_W;
            match_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            working_q <= working_d;
            idx_q     <= idx_d;
            cmp_a_q   <= cmp_a_d;
            cmp_sel_q <= cmp_sel_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            match_q   <= match_d;
        end
    end

    assign cmp_a   = cmp_a_q;
    assign cmp_sel = cmp_sel_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;
    assign match   = match_q;

endmodule

// File: tb/tb_comparator_search.sv
// Randomized self-checking bench for comparator_search: a behavioural comparator
// holds B, and a bit-by-bit search model predicts probes, result and match.
module tb_comparator_search;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [3:0] cmp_a;
    logic [1:0] cmp_sel;
    logic       cmp_o;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic       match;

    logic [3:0] b_val;
    int         n_vec = 0;
    int         n_err = 0;
    int         done_cnt = 0;
    int         done_exp = 0;
    logic [3:0] last_res = 4'd0;
    logic       last_match = 1'b0;

    comparator_search #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .cmp_a   (cmp_a),
        .cmp_sel (cmp_sel),
        .cmp_o   (cmp_o),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .match   (match)
    );

    always #5 clk = ~clk;

    // External comparator with hidden operand B
    always_comb begin
        case (cmp_sel)
            2'b00:   cmp_o = (cmp_a > b_val);
            2'b01:   cmp_o = (cmp_a < b_val);
            2'b10:   cmp_o = (cmp_a == b_val);
            default: cmp_o = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_val({tag, "_sel"},  {30'd0, cmp_sel}, 32'd3);
        check_val({tag, "_a"},    {28'd0, cmp_a}, 32'd0);
    endtask

    // One full search; B is b0 in the cycles before step chg and b1 from then on.
    // Returns in the done cycle, so the caller can launch a back-to-back start.
    task automatic do_search(input logic [3:0] b0, input logic [3:0] b1,
                             input int chg, input bit busy_start);
        logic [3:0] res;
        logic [3:0] probe;
        logic [3:0] bi;
        logic       exp_match;
        int         busy_cyc;
        b_val = b0;
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        res      = 4'd0;
        busy_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            bi    = (i >= chg) ? b1 : b0;
            b_val = bi;
            probe = res | (4'b1000 >> i);
            check_val("probe_a",   {28'd0, cmp_a},   {28'd0, probe});
            check_val("probe_sel", {30'd0, cmp_sel}, 32'd0);
            if (busy) busy_cyc++;
            if (!(probe > bi)) res = probe;
            if (busy_start && i == 1) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        bi    = (4 >= chg) ? b1 : b0;
        b_val = bi;
        check_val("verify_a",   {28'd0, cmp_a},   {28'd0, res});
        check_val("verify_sel", {30'd0, cmp_sel}, 32'd2);
        if (busy) busy_cyc++;
        exp_match = (res == bi);
        @(posedge clk); #1;
        check_val("done",     {31'd0, done},   32'd1);
        check_val("result",   {28'd0, result}, {28'd0, res});
        check_val("match",    {31'd0, match},  {31'd0, exp_match});
        check_val("busy_end", {31'd0, busy},   32'd0);
        check_val("busy_len", busy_cyc,        32'd5);
        if (chg > 4) check_val("res_eq_b", {28'd0, result}, {28'd0, b0});
        done_exp++;
        last_res   = res;
        last_match = exp_match;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] rb0;
        logic [3:0] rb1;
        int         rchg;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        b_val = 4'd0;
        #12;
        check_idle_outputs("rst");
        check_val("rst_done",   {31'd0, done},   32'd0);
        check_val("rst_result", {28'd0, result}, 32'd0);
        check_val("rst_match",  {31'd0, match},  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Nominal and extremes
        do_search(4'b1011, 4'b1011, 5, 1'b0);
        @(posedge clk); #1;
        check_val("done_pulse", {31'd0, done}, 32'd0);
        do_search(4'b0000, 4'b0000, 5, 1'b0);
        @(posedge clk); #1;
        do_search(4'b1111, 4'b1111, 5, 1'b0);
        @(posedge clk); #1;

        // B changes after the second probe edge
        do_search(4'b0110, 4'b0001, 2, 1'b0);
        @(posedge clk); #1;

        // Abort in the second PROBE cycle
        b_val = 4'b0101;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_idle_outputs("abort");
        repeat (6) @(posedge clk);
        #1;
        check_val("abort_result", {28'd0, result}, {28'd0, last_res});
        check_val("abort_match",  {31'd0, match},  {31'd0, last_match});
        check_val("abort_dones",  done_cnt, done_exp);

        // start together with abort in IDLE
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check_idle_outputs("start_abort");
        repeat (6) @(posedge clk);
        #1;
        check_val("start_abort_dones", done_cnt, done_exp);

        // Back-to-back searches with a start pulse while busy
        do_search(4'b0011, 4'b0011, 5, 1'b1);
        do_search(4'b1100, 4'b1100, 5, 1'b1);
        @(posedge clk); #1;
        check_val("b2b_idle", {31'd0, busy}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check_val("b2b_dones", done_cnt, done_exp);

        // Asynchronous reset in the third PROBE cycle
        b_val = 4'b0110;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("arst");
        check_val("arst_done",   {31'd0, done},   32'd0);
        check_val("arst_result", {28'd0, result}, 32'd0);
        check_val("arst_match",  {31'd0, match},  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("arst_dones", done_cnt, done_exp);
        do_search(4'b1001, 4'b1001, 5, 1'b0);
        @(posedge clk); #1;

        // Randomized searches, some with B changing mid-search
        for (int k = 0; k < 24; k++) begin
            rb0  = 4'($urandom_range(0, 15));
            rb1  = 4'($urandom_range(0, 15));
            rchg = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 5;
            do_search(rb0, rb1, rchg, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
                check_val("rnd_done_off", {31'd0, done}, 32'd0);
            end
        end
        @(posedge clk); #1;
        check_val("total_dones", done_cnt, done_exp);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
